// File: rtl/mac_instruction_sequencer.sv
// Program-counter and issue stage for the MAC engine: fetches from instruction memory,
// runs repeat counts and one hardware loop level, and issues ops over valid/ready.
module mac_instruction_sequencer #(
    parameter int unsigned IM_SIZE = 2,
    parameter int unsigned FIELD_W = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [31:0]          PC,
    input  logic [2*FIELD_W-1:0] instruction,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [FIELD_W-1:0]   op_payload,
    output logic                 op_last,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned PC_W    = 32;
    localparam int unsigned TGT_W   = 12;
    localparam int unsigned CNT_LSB = 12;
    localparam int unsigned OPC_LSB = 28;

    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_EXEC = 4'd1;
    localparam logic [3:0] OPC_LOOP = 4'd2;
    localparam logic [3:0] OPC_HALT = 4'd3;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FINISH} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   loop_rem_q, loop_rem_d;
    logic               loop_active_q, loop_active_d;
    logic               valid_d, last_d, busy_d, done_d, error_d;
    logic [FIELD_W-1:0] payload_d;

    // Field decode of the live instruction word
    logic [3:0]         opcode;
    logic [CNT_W-1:0]   count;
    logic [TGT_W-1:0]   target;
    logic [FIELD_W-1:0] field1;
    logic [PC_W-1:0]    pc_inc;
    logic               pc_end;
    logic               target_bad;

    assign opcode     = instruction[OPC_LSB +: 4];
    assign count      = instruction[CNT_LSB +: CNT_W];
    assign target     = instruction[TGT_W-1:0];
    assign field1     = instruction[FIELD_W +: FIELD_W];
    assign pc_inc     = PC + PC_W'(1);
    assign pc_end     = (pc_inc == PC_W'(IM_SIZE));
    assign target_bad = (PC_W'(target) >= PC_W'(IM_SIZE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            PC            <= '0;
            rep_q         <= '0;
            loop_rem_q    <= '0;
            loop_active_q <= 1'b0;
            op_valid      <= 1'b0;
            op_payload    <= '0;
            op_last       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            PC            <= pc_d;
            rep_q         <= rep_d;
            loop_rem_q    <= loop_rem_d;
            loop_active_q <= loop_active_d;
            op_valid      <= valid_d;
            op_payload    <= payload_d;
            op_last       <= last_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = PC;
        rep_d         = rep_q;
        loop_rem_d    = loop_rem_q;
        loop_active_d = loop_active_q;
        valid_d       = op_valid;
        payload_d     = op_payload;
        last_d        = op_last;
        error_d       = error;

        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = FETCH;
                        pc_d          = '0;
                        loop_active_d = 1'b0;
                        error_d       = 1'b0;
                    end
                end
                FETCH: begin
                    case (opcode)
                        OPC_NOP: begin
                            pc_d = pc_inc;
                            if (pc_end) state_d = FINISH;
                        end
                        OPC_EXEC: begin
                            rep_d     = (count == '0) ? '0 : count - CNT_W'(1);
                            payload_d = field1;
                            last_d    = (count <= CNT_W'(1));
                            valid_d   = 1'b1;
                            state_d   = ISSUE;
                        end
                        OPC_LOOP: begin
                            if (target_bad) begin
                                error_d = 1'b1;
                                state_d = FINISH;
                            end else if (!loop_active_q && count > CNT_W'(1)) begin
                                loop_active_d = 1'b1;
                                loop_rem_d    = count - CNT_W'(2);
                                pc_d          = PC_W'(target);
                            end else if (loop_active_q && loop_rem_q != '0) begin
                                loop_rem_d = loop_rem_q - CNT_W'(1);
                                pc_d       = PC_W'(target);
                            end else begin
                                loop_active_d = 1'b0;
                                pc_d          = pc_inc;
                                if (pc_end) state_d = FINISH;
                            end
                        end
                        OPC_HALT: state_d = FINISH;
                        default: begin
                            error_d = 1'b1;
                            state_d = FINISH;
                        end
                    endcase
                end
                ISSUE: begin
                    // op_valid is always high here; payload/last hold until accepted
                    if (op_ready) begin
                        if (rep_q != '0) begin
                            rep_d  = rep_q - CNT_W'(1);
                            last_d = (rep_q == CNT_W'(1));
                        end else begin
                            valid_d = 1'b0;
                            pc_d    = pc_inc;
                            state_d = pc_end ? FINISH : FETCH;
                        end
                    end
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        done_d = (state_d == FINISH);
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mac_instruction_sequencer.sv
// Scoreboard bench for mac_instruction_sequencer: a two-word instruction memory model,
// expected ops queued per program and compared as the DUT hands them off.
module tb_mac_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, op_ready;
    logic [31:0] PC;
    logic [63:0] instruction;
    logic        op_valid, op_last, busy, done, error;
    logic [31:0] op_payload;
    logic [63:0] im [2];

    typedef struct packed {
        logic [31:0] pc;
        logic        last;
        logic [31:0] pay;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    mac_instruction_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .PC(PC),
        .instruction(instruction), .op_valid(op_valid), .op_ready(op_ready),
        .op_payload(op_payload), .op_last(op_last), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always_comb instruction = (PC < 32'd2) ? im[PC[0]] : 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] opc, input logic [15:0] cnt,
                                       input logic [11:0] tgt, input logic [31:0] pay);
        return {pay, opc, cnt, tgt};
    endfunction

    // Handshake monitor: every accepted op must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset && op_valid && op_ready && !abort) begin
            if (sb.size() == 0) begin
                check("unexpected_op", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("op_payload", 64'(op_payload), 64'(e.pay));
                check("op_last", 64'(op_last), 64'(e.last));
                check("op_pc", 64'(PC), 64'(e.pc));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ops(input int n, input logic [31:0] pay, input bit last_each);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = 32'd0;
            e.pay  = pay;
            e.last = last_each ? 1'b1 : (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_prog();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = op_valid;
        end
        check({tag, "_valid_timeout"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done_timeout"}, 64'(seen), 64'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_ops_left"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 64'(PC), 64'd0);
        check({tag, "_valid"}, 64'(op_valid), 64'd0);
        check({tag, "_payload"}, 64'(op_payload), 64'd0);
        check({tag, "_last"}, 64'(op_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; op_ready = 1'b0;
        im[0] = 64'd0; im[1] = 64'd0;
        #12;
        check_reset_outputs("reset");
        cyc();
        reset = 1'b1;

        // T1: three repetitions, then HALT
        im[0] = mk(4'd1, 16'd3, 12'd0, 32'hA5);
        im[1] = mk(4'd3, 16'd0, 12'd0, 32'h0);
        op_ready = 1'b1;
        push_ops(3, 32'hA5, 1'b0);
        start_prog();
        check("t1_busy_n1", 64'(busy), 64'd1);
        check("t1_valid_n1", 64'(op_valid), 64'd0);
        cyc();
        check("t1_valid_n2", 64'(op_valid), 64'd1);
        check("t1_payload_n2", 64'(op_payload), 64'hA5);
        wait_done("t1");
        check("t1_pc_hold", 64'(PC), 64'd1);
        check("t1_error", 64'(error), 64'd0);

        // T2: stall op 2 for four cycles, with an ignored start while busy
        op_ready = 1'b0;
        push_ops(3, 32'hA5, 1'b0);
        start_prog();
        wait_valid("t2");
        cyc();
        op_ready = 1'b1;
        cyc();
        op_ready = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_stall_valid", 64'(op_valid), 64'd1);
            check("t2_stall_payload", 64'(op_payload), 64'hA5);
            check("t2_stall_last", 64'(op_last), 64'd0);
        end
        cyc();
        start = 1'b0;
        op_ready = 1'b1;
        wait_done("t2");
        check("t2_pc_hold", 64'(PC), 64'd1);

        // T3: single EXEC inside a four-pass loop
        im[0] = mk(4'd1, 16'd1, 12'd0, 32'h7);
        im[1] = mk(4'd2, 16'd4, 12'd0, 32'h0);
        push_ops(4, 32'h7, 1'b1);
        start_prog();
        wait_done("t3");
        check("t3_pc_end", 64'(PC), 64'd2);

        // T4: illegal opcode
        im[0] = {32'h0, 32'hF000_0000};
        start_prog();
        wait_done("t4");
        check("t4_error", 64'(error), 64'd1);

        // T5: abort with an op stalled; the accepted start also clears error
        im[0] = mk(4'd1, 16'd3, 12'd0, 32'hA5);
        im[1] = mk(4'd3, 16'd0, 12'd0, 32'h0);
        op_ready = 1'b0;
        start_prog();
        check("t4_error_cleared", 64'(error), 64'd0);
        wait_valid("t5");
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_abort_valid", 64'(op_valid), 64'd0);
        check("t5_abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_done", 64'(done), 64'd0);
        end
        op_ready = 1'b1;
        push_ops(3, 32'hA5, 1'b0);
        start_prog();
        wait_done("t5_rerun");

        // abort and start together in IDLE
        cyc();
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 64'(busy), 64'd0);
        cyc();
        check("abort_start_busy2", 64'(busy), 64'd0);

        // T6: asynchronous reset mid-ISSUE
        op_ready = 1'b0;
        start_prog();
        wait_valid("t6");
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        cyc();
        cyc();
        reset = 1'b1;
        op_ready = 1'b1;
        push_ops(3, 32'hA5, 1'b0);
        start_prog();
        wait_done("t6_rerun");
        check("t6_pc_hold", 64'(PC), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
